vce_scan_doubler: RTL and testbench

- Downstream consumer of the VCE's 24-bit RGB pixel stream.
- Captures each incoming PC Engine scanline into a ping-pong line buffer.
- Replays each stored line twice at double line rate with its own VGA-style H/V sync and blanking, producing a 31 kHz progressive output.
- Sits between the VCE colour output and the board video DAC/VGA pins.

---
 rtl/vce_scan_doubler.sv | 230 +++++++++++++++++++++++
 tb/tb_vce_scan_doubler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vce_scan_doubler.sv
// vce_scan_doubler: line-doubling scan converter for the VCE 24-bit RGB stream.
// Each input scanline is captured into one bank of a ping-pong line buffer. The line
// is then replayed twice at double line rate with its own VGA-style sync and blanking,
// which gives a 31 kHz progressive output.
//
// Ports:
//   clk, reset_N               system clock, asynchronous active-low reset
//   pix_valid, pix_rgb         input pixel strobe and {R,G,B} data
//   line_start, frame_start    one-clk input scanline / frame markers
//   out_ce                     output pixel clock enable; the whole reader steps on it
//   VGA_R/G/B, VGA_HS, VGA_VS  registered video and syncs (both syncs active high)
//   VGA_BLANK_N                high in the visible region
//   ovf                        one-clk pulse when an input pixel is dropped (line too long)
module vce_scan_doubler #(
  parameter int unsigned MAX_PIX  = 512,
  parameter int unsigned H_TOTAL  = 682,
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned HS_START = 530,
  parameter int unsigned HS_LEN   = 64,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned VS_START = 490,
  parameter int unsigned VS_LEN   = 2
) (
  input  logic        clk,
  input  logic        reset_N,
  input  logic        pix_valid,
  input  logic [23:0] pix_rgb,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic        out_ce,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        ovf
);

  localparam int unsigned XW = $clog2(MAX_PIX);
  localparam int unsigned LW = $clog2(MAX_PIX + 1);
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = 10;
  localparam logic [VW-1:0] VMax = '1;

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StWait} rd_state_e;

  // Writer side
  logic          wr_bank_q, wr_bank_d;
  logic [LW-1:0] wr_x_q, wr_x_d;
  logic [LW-1:0] len0_q, len0_d, len1_q, len1_d;
  logic          rd_bank_q, rd_bank_d;
  logic          kick_q, kick_d;
  logic          frame_q, frame_d;
  logic          ovf_q, ovf_d;
  logic          we;
  logic [XW:0]   waddr;

  // Reader side
  rd_state_e     state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d, v_inc;
  logic          rd_sel_q, rd_sel_d;
  logic [LW-1:0] rd_len_q, rd_len_d;
  logic [XW:0]   raddr;

  // Output pipeline: stage 1 lines up with the synchronous buffer read, stage 2 drives pins
  logic          act1_q, act1_d, pix1_q, pix1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [23:0]   rdata_q;
  logic [23:0]   buf_mem [2**(XW+1)];

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_x_d    = wr_x_q;
    len0_d    = len0_q;
    len1_d    = len1_q;
    rd_bank_d = rd_bank_q;
    kick_d    = kick_q;
    frame_d   = frame_q;
    ovf_d     = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    // Pending flags are consumed by the reader on out_ce; a new event re-arms them.
    if (out_ce) begin
      kick_d  = 1'b0;
      frame_d = 1'b0;
    end
    if (line_start) begin
      if (wr_bank_q) len1_d = wr_x_q;
      else           len0_d = wr_x_q;
      rd_bank_d = wr_bank_q;
      wr_bank_d = ~wr_bank_q;
      wr_x_d    = '0;
      kick_d    = 1'b1;
    end
    if (frame_start) frame_d = 1'b1;
    // Uses the post-line_start bank/x so a coincident pixel lands at x=0 of the new bank.
    if (pix_valid) begin
      if (32'(wr_x_d) < MAX_PIX) begin
        we     = 1'b1;
        waddr  = {wr_bank_d, wr_x_d[XW-1:0]};
        wr_x_d = wr_x_d + LW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign v_inc = (v_q == VMax) ? v_q : v_q + VW'(1);

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    rd_sel_d = rd_sel_q;
    rd_len_d = rd_len_q;
    if (out_ce) begin
      unique case (state_q)
        StIdle, StWait: begin
          if (kick_q) begin
            state_d  = StPass1;
            h_d      = '0;
            rd_sel_d = rd_bank_q;
            rd_len_d = rd_bank_q ? len1_q : len0_q;
          end
        end
        StPass1, StPass2: begin
          if (kick_q) begin
            // A new input line aborts the pass in progress.
            state_d  = StPass1;
            h_d      = '0;
            v_d      = v_inc;
            rd_sel_d = rd_bank_q;
            rd_len_d = rd_bank_q ? len1_q : len0_q;
          end else if (32'(h_q) == H_TOTAL - 1) begin
            h_d     = '0;
            v_d     = v_inc;
            state_d = (state_q == StPass1) ? StPass2 : StWait;
          end else begin
            h_d = h_q + HW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
      if (frame_q) v_d = '0;
    end
  end

  assign raddr = {rd_sel_q, h_q[XW-1:0]};

  always_comb begin
    logic in_pass;
    in_pass   = (state_q == StPass1) || (state_q == StPass2);
    act1_d    = in_pass && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    pix1_d    = act1_d && (32'(h_q) < 32'(rd_len_q));
    hs1_d     = in_pass && (32'(h_q) >= HS_START) && (32'(h_q) < HS_START + HS_LEN);
    vs1_d     = (32'(v_q) >= VS_START) && (32'(v_q) < VS_START + VS_LEN);
    rgb_d     = pix1_q ? rdata_q : 24'h0;
    hs_d      = hs1_q;
    vs_d      = vs1_q;
    blank_n_d = act1_q;
  end

  // Line buffer: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we)     buf_mem[waddr] <= pix_rgb;
    if (out_ce) rdata_q <= buf_mem[raddr];
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_bank_q <= 1'b0;
      wr_x_q    <= '0;
      len0_q    <= '0;
      len1_q    <= '0;
      rd_bank_q <= 1'b0;
      kick_q    <= 1'b0;
      frame_q   <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= StIdle;
      h_q       <= '0;
      v_q       <= '0;
      rd_sel_q  <= 1'b0;
      rd_len_q  <= '0;
      act1_q    <= 1'b0;
      pix1_q    <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      blank_n_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_x_q    <= wr_x_d;
      len0_q    <= len0_d;
      len1_q    <= len1_d;
      rd_bank_q <= rd_bank_d;
      kick_q    <= kick_d;
      frame_q   <= frame_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      rd_sel_q  <= rd_sel_d;
      rd_len_q  <= rd_len_d;
      if (out_ce) begin
        act1_q    <= act1_d;
        pix1_q    <= pix1_d;
        hs1_q     <= hs1_d;
        vs1_q     <= vs1_d;
        rgb_q     <= rgb_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        blank_n_q <= blank_n_d;
      end
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_vce_scan_doubler.sv
// Bench for vce_scan_doubler. Stimulus is built as a per-clock queue and replayed.
// The reference model tracks input lines and the out_ce tick at which each line is
// taken up by the reader, then derives the expected output of any tick arithmetically:
// an output line lasts H_TOTAL ticks and is shown twice, and the pins lag by 2 ticks.
module tb_vce_scan_doubler;
  localparam int MAXP = 512, HT = 682, HA = 512, HSS = 530, HSL = 64;
  localparam int VA = 480, VSS = 490, VSL = 2;

  typedef struct packed {
    bit          ls;
    bit          fs;
    bit          pv;
    logic [23:0] rgb;
    bit          ce;
  } stim_t;

  logic        clk = 1'b0, reset_N = 1'b0;
  logic        pix_valid = 1'b0, line_start = 1'b0, frame_start = 1'b0, out_ce = 1'b0;
  logic [23:0] pix_rgb = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, ovf;
  logic [26:0] dut_vid;

  int n_tests = 0, n_fail = 0;

  vce_scan_doubler dut (
    .clk(clk), .reset_N(reset_N), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .line_start(line_start), .frame_start(frame_start), .out_ce(out_ce),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .ovf(ovf)
  );

  always #5 clk = ~clk;
  assign dut_vid = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};

  // Model state
  int          tick = 0;
  int          cur_cnt, pend_len;
  logic [23:0] cur_line [MAXP];
  logic [23:0] pend_line [MAXP];
  bit          kpend, fpend, have_prev;
  int          prev_tick, prev_v, k_next;
  int          k_tick [2];
  int          k_v [2];
  int          k_len [2];
  bit          k_valid [2];
  logic [23:0] k_data [2][MAXP];
  logic [26:0] exp_vid;
  bit          exp_ovf;
  bit          ce_rand = 1'b0;
  stim_t       sq [$];

  task automatic model_reset();
    cur_cnt = 0; pend_len = 0; kpend = 0; fpend = 0; have_prev = 0; k_next = 0;
    k_valid[0] = 0; k_valid[1] = 0;
  endtask

  // Expected pins after out_ce tick m: they show the reader position after tick m-2.
  function automatic logic [26:0] model_out(input int m);
    int b = -1;
    int d, h, v, pass;
    bit in_pass, act, hs, vs;
    logic [23:0] px = '0;
    for (int s = 0; s < 2; s++)
      if (k_valid[s] && k_tick[s] <= m - 2 && (b < 0 || k_tick[s] > k_tick[b])) b = s;
    if (b < 0) return '0;
    d = m - 2 - k_tick[b];
    pass = d / HT;
    h = d % HT;
    in_pass = (pass < 2);
    v = k_v[b] + (in_pass ? pass : 2);
    if (v > 1023) v = 1023;
    act = in_pass && h < HA && v < VA;
    hs  = in_pass && h >= HSS && h < HSS + HSL;
    vs  = v >= VSS && v < VSS + VSL;
    if (act && h < k_len[b]) px = k_data[b][h];
    return {px, hs, vs, act};
  endfunction

  // Drives one clock of stimulus and advances the model; leaves exp_vid/exp_ovf.
  task automatic step(input stim_t s);
    bit fz;
    int v, e, k;
    line_start = s.ls; frame_start = s.fs; pix_valid = s.pv; pix_rgb = s.rgb; out_ce = s.ce;
    @(posedge clk);
    #1;
    if (s.ce) begin
      tick++;
      fz = fpend;
      if (kpend) begin
        if (fz || !have_prev) v = 0;
        else begin
          e = tick - prev_tick;
          v = prev_v + ((e <= HT) ? 1 : 2);
          if (v > 1023) v = 1023;
        end
        k = k_next; k_next ^= 1;
        k_tick[k] = tick; k_v[k] = v; k_len[k] = pend_len; k_valid[k] = 1;
        for (int j = 0; j < MAXP; j++) k_data[k][j] = pend_line[j];
        have_prev = 1; prev_tick = tick; prev_v = v;
      end
      kpend = 0; fpend = 0;
    end
    if (s.ls) begin
      for (int j = 0; j < MAXP; j++) pend_line[j] = cur_line[j];
      pend_len = cur_cnt; cur_cnt = 0; kpend = 1;
    end
    if (s.fs) fpend = 1;
    exp_ovf = 0;
    if (s.pv) begin
      if (cur_cnt < MAXP) begin cur_line[cur_cnt] = s.rgb; cur_cnt++; end
      else exp_ovf = 1;
    end
    if (s.ce) exp_vid = model_out(tick);
  endtask

  function automatic bit pick_ce();
    return ce_rand ? bit'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) sq.push_back('{0, 0, 0, 24'h0, pick_ce()});
  endtask

  task automatic add_ls(input bit fs);
    sq.push_back('{1, fs, 0, 24'h0, pick_ce()});
  endtask

  task automatic add_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) add_idle(1);
      sq.push_back('{0, 0, 1, 24'($urandom), pick_ce()});
    end
  endtask

  task automatic test_reset();
    reset_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1; pix_rgb = 24'($urandom); out_ce = 1'b1; line_start = (i == 1);
      @(posedge clk); #1;
      n_tests++;
      if (dut_vid !== 27'h0 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got vid=%h ovf=%b, want 0", dut_vid, ovf);
      end
    end
    pix_valid = 0; line_start = 0;
    @(negedge clk); reset_N = 1'b1;
    model_reset();
    sq.delete();
    add_idle(2000);
    foreach (sq[i]) begin
      step(sq[i]);
      n_tests++;
      if (ovf !== exp_ovf || (sq[i].ce && dut_vid !== exp_vid)) begin
        n_fail++;
        $display("FAIL idle clk %0d: got vid=%h ovf=%b, want vid=%h ovf=%b",
                 i, dut_vid, ovf, exp_vid, exp_ovf);
      end
    end
  endtask

  task automatic test_full_line();
    sq.delete();
    add_ls(1);
    for (int x = 0; x < MAXP; x++) sq.push_back('{0, 0, 1, 24'(x), 1'b1});
    add_ls(0);
    add_idle(1500);
    foreach (sq[i]) begin
      step(sq[i]);
      n_tests++;
      if (ovf !== exp_ovf) begin
        n_fail++; $display("FAIL full_line ovf clk %0d: got %b want %b", i, ovf, exp_ovf);
      end
      if (sq[i].ce) begin
        n_tests++;
        if (dut_vid !== exp_vid) begin
          n_fail++;
          $display("FAIL full_line video tick %0d: got %h want %h", tick, dut_vid, exp_vid);
        end
      end
    end
  endtask

  task automatic test_short_and_ovf();
    int n_ovf = 0;
    sq.delete();
    add_pixels(300); add_ls(0); add_idle(1500);
    add_pixels(520); add_ls(0); add_idle(1500);
    foreach (sq[i]) begin
      step(sq[i]);
      n_ovf += int'(ovf);
      n_tests++;
      if (ovf !== exp_ovf) begin
        n_fail++; $display("FAIL short_ovf ovf clk %0d: got %b want %b", i, ovf, exp_ovf);
      end
      if (sq[i].ce) begin
        n_tests++;
        if (dut_vid !== exp_vid) begin
          n_fail++;
          $display("FAIL short_ovf video tick %0d: got %h want %h", tick, dut_vid, exp_vid);
        end
      end
    end
    n_tests++;
    if (n_ovf != 8) begin
      n_fail++; $display("FAIL ovf_count: got %0d pulses, want 8", n_ovf);
    end
  endtask

  task automatic test_abort();
    sq.delete();
    add_pixels(400); add_ls(0);
    // Next line_start lands about 400 ticks into the second pass of this line.
    for (int i = 0; i < HT + 399; i++)
      sq.push_back('{0, 0, bit'(i < 300 && $urandom_range(0, 3) != 0), 24'($urandom), 1'b1});
    add_ls(0);
    add_idle(1500);
    foreach (sq[i]) begin
      step(sq[i]);
      n_tests++;
      if (ovf !== exp_ovf) begin
        n_fail++; $display("FAIL abort ovf clk %0d: got %b want %b", i, ovf, exp_ovf);
      end
      if (sq[i].ce) begin
        n_tests++;
        if (dut_vid !== exp_vid) begin
          n_fail++;
          $display("FAIL abort video tick %0d: got %h want %h", tick, dut_vid, exp_vid);
        end
      end
    end
  endtask

  // Short input lines each abort the first pass, so v_cnt steps by one per line and
  // walks through the vsync window, the end of active video and saturation.
  task automatic test_vsync();
    int vs_seen = 0;
    sq.delete();
    add_ls(1);
    for (int l = 0; l < 1030; l++) begin
      for (int c = 0; c < 7; c++)
        sq.push_back('{0, 0, bit'($urandom_range(0, 1)), 24'($urandom), 1'b1});
      add_ls(0);
    end
    add_idle(1500);
    foreach (sq[i]) begin
      step(sq[i]);
      vs_seen += int'(VGA_VS);
      n_tests++;
      if (ovf !== exp_ovf) begin
        n_fail++; $display("FAIL vsync ovf clk %0d: got %b want %b", i, ovf, exp_ovf);
      end
      if (sq[i].ce) begin
        n_tests++;
        if (dut_vid !== exp_vid) begin
          n_fail++;
          $display("FAIL vsync video tick %0d: got %h want %h", tick, dut_vid, exp_vid);
        end
      end
    end
    n_tests++;
    if (vs_seen != 16) begin
      n_fail++; $display("FAIL vsync_width: got %0d ticks high, want 16", vs_seen);
    end
  endtask

  task automatic test_gated_ce();
    ce_rand = 1'b1;
    sq.delete();
    add_pixels($urandom_range(200, 520)); add_ls(0); add_idle(3500);
    add_pixels(150); add_ls(0); add_idle(3500);
    ce_rand = 1'b0;
    foreach (sq[i]) begin
      step(sq[i]);
      n_tests++;
      if (ovf !== exp_ovf) begin
        n_fail++; $display("FAIL gated ovf clk %0d: got %b want %b", i, ovf, exp_ovf);
      end
      if (sq[i].ce) begin
        n_tests++;
        if (dut_vid !== exp_vid) begin
          n_fail++;
          $display("FAIL gated video tick %0d: got %h want %h", tick, dut_vid, exp_vid);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    sq.delete();
    add_pixels(300); add_ls(0); add_idle(200);
    foreach (sq[i]) begin
      step(sq[i]);
      n_tests++;
      if (ovf !== exp_ovf || (sq[i].ce && dut_vid !== exp_vid)) begin
        n_fail++;
        $display("FAIL pre_reset clk %0d: got vid=%h ovf=%b, want vid=%h ovf=%b",
                 i, dut_vid, ovf, exp_vid, exp_ovf);
      end
    end
    pix_valid = 0; line_start = 0; frame_start = 0;
    #2 reset_N = 1'b0;
    #1;
    n_tests++;
    if (dut_vid !== 27'h0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got vid=%h ovf=%b, want 0", dut_vid, ovf);
    end
    @(posedge clk); @(negedge clk);
    reset_N = 1'b1;
    model_reset();
    sq.delete();
    add_pixels(100); add_ls(0); add_idle(1500);
    foreach (sq[i]) begin
      step(sq[i]);
      n_tests++;
      if (ovf !== exp_ovf || (sq[i].ce && dut_vid !== exp_vid)) begin
        n_fail++;
        $display("FAIL post_reset clk %0d: got vid=%h ovf=%b, want vid=%h ovf=%b",
                 i, dut_vid, ovf, exp_vid, exp_ovf);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_line();
    test_short_and_ovf();
    test_abort();
    test_vsync();
    test_gated_ce();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
